lock_buffer: RTL and testbench
==============================

# lock_buffer

Parameterised pipeline-stage register with stall (lock) and flush control. Sits between CPU pipeline stages. Each clock it captures the upstream word unless locked; it holds its content while locked and clears to a bubble on flush. An optional saturating stall counter exposes lock activity for performance monitoring.

## Interface
Parameters:
- WIDTH, 16, data width in bits (≥1).
- FLUSH_VALUE, all-zero, value loaded on reset and on flush (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, synchronous and active-low.
- in  input  WIDTH  upstream data word.
- dis  input  1  lock/stall: when 1, hold the current contents.
- flush  input  1  clear the stage to FLUSH_VALUE.
- out  output  WIDTH  registered data.
- valid  output  1  1 = out holds a loaded word; 0 = bubble (after reset or flush).
- stall_cnt  output  16  saturating lock-cycle count (present only with LOCK_BUFFER_STALL_CNT_EN).

## Operation
- Evaluated at each rising clk edge, in strict priority:
  1. rst_n=0: out←FLUSH_VALUE, valid←0, stall_cnt←0.
  2. flush=1: out←FLUSH_VALUE, valid←0. This applies regardless of dis, so flush overrides lock.
  3. dis=1: out and valid hold.
  4. Otherwise: out←in, valid←1.
- No FSM; a single data register plus a valid flag.
- Flush is level-sensitive. While it is held, the stage re-clears every cycle.
- When dis is released, the stage resumes loading on the first edge where both dis=0 and flush=0.
- X/Z on `in` propagates only when the stage loads.
- Stall counter: increments by 1 on each edge where rst_n=1, dis=1 and flush=0. It saturates at 16'hFFFF and never wraps. It is not cleared by flush.

## Timing
- Latency: 1 cycle. `in` sampled at edge N appears on out right after edge N.
- All outputs are registered; there is no combinational path from any input to any output.
- Reset values: out=FLUSH_VALUE, valid=0, stall_cnt=0.
- Reset asserted mid-operation overrides dis and flush on the same edge.
- Simultaneous dis=1 and flush=1: flush wins; the stall counter does not increment.
- Simultaneous rst_n=0 with anything else: reset wins.
- dis asserted on edge N: out keeps the value loaded at edge N-1.

## Configuration
- LOCK_BUFFER_STALL_CNT_EN defined: stall_cnt port and its 16-bit saturating counter are compiled in.
- LOCK_BUFFER_STALL_CNT_EN undefined: no stall_cnt port and no counter logic. All other behaviour is identical.

## Structure
- Package lock_buffer_pkg holds:
  - LB_DEFAULT_WIDTH = 16
  - LB_STALL_CNT_W = 16
  - a function returning the saturating increment.
- One natural sub-module: lock_buffer_sat_cnt, a generic saturating counter with enable and synchronous active-low reset. It is instantiated only under the macro.
- The top holds the data/valid register and the priority mux.

## Test plan
- Reset: rst_n=0 for 2 edges with in=16'h1234 → out=16'h0000, valid=0, stall_cnt=0.
- Load: rst_n=1, dis=0, flush=0; in=16'hAFAF then 16'hFAFA on successive edges → out=16'hAFAF, then 16'hFAFA one cycle later; valid=1.
- Lock: dis=1 with in=16'hFFFF, then 16'h5555 → out stays 16'hFAFA; stall_cnt increments by 1 per locked edge.
- Flush while locked: dis=1, flush=1 → out=16'h0000 and valid=0 next edge; stall_cnt unchanged.
- Release: flush=1 and dis=0 → out stays 16'h0000. Then flush=0 with in=16'h5555 → out=16'h5555, valid=1 one edge later.
- Saturation/mid-op reset (macro on): hold dis=1 for more than 65535 cycles → stall_cnt=16'hFFFF. Then rst_n=0 for one edge → all outputs return to reset values.

Source files
------------

// File: rtl/lock_buffer_pkg.sv
// Shared widths and the saturating-increment helper for the lock_buffer pipeline stage.
package lock_buffer_pkg;

   localparam int unsigned LB_DEFAULT_WIDTH = 16;
   localparam int unsigned LB_STALL_CNT_W   = 16;

   // Next counter value; holds at all-ones instead of wrapping.
   function automatic logic [LB_STALL_CNT_W-1:0] lb_sat_inc(input logic [LB_STALL_CNT_W-1:0] v);
      return (v == '1) ? v : v + LB_STALL_CNT_W'(1);
   endfunction

endpackage

// File: rtl/lock_buffer_if.sv
// Upstream/downstream signal bundle of the lock_buffer stage.
// stall_cnt exists only when LOCK_BUFFER_STALL_CNT_EN is defined.
interface lock_buffer_if
   import lock_buffer_pkg::*;
#(
   parameter int unsigned WIDTH = LB_DEFAULT_WIDTH
) ();

   logic [WIDTH-1:0] in;
   logic             dis;
   logic             flush;
   logic [WIDTH-1:0] out;
   logic             valid;
`ifdef LOCK_BUFFER_STALL_CNT_EN
   logic [LB_STALL_CNT_W-1:0] stall_cnt;

   modport master (output in, dis, flush, input out, valid, stall_cnt);
   modport slave  (input in, dis, flush, output out, valid, stall_cnt);
`else
   modport master (output in, dis, flush, input out, valid);
   modport slave  (input in, dis, flush, output out, valid);
`endif

endinterface

// File: rtl/lock_buffer_sat_cnt.sv
// Saturating up-counter with enable and synchronous active-low reset.
module lock_buffer_sat_cnt
   import lock_buffer_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   output logic [LB_STALL_CNT_W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= lb_sat_inc(cnt);
      end
   end

endmodule

// File: rtl/lock_buffer.sv
// Pipeline-stage register with lock (dis) and flush; flush overrides lock.
// Optional stall counter compiled in with LOCK_BUFFER_STALL_CNT_EN.
module lock_buffer
   import lock_buffer_pkg::*;
#(
   parameter int unsigned      WIDTH       = LB_DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] FLUSH_VALUE = '0
) (
   input logic           clk,
   input logic           rst_n,
   lock_buffer_if.slave  bus
);

   logic [WIDTH-1:0] data_q;
   logic             valid_q;

   // Priority: reset, flush, lock, load.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_q  <= FLUSH_VALUE;
         valid_q <= 1'b0;
      end else if (bus.flush) begin
         data_q  <= FLUSH_VALUE;
         valid_q <= 1'b0;
      end else if (!bus.dis) begin
         data_q  <= bus.in;
         valid_q <= 1'b1;
      end
   end

   assign bus.out   = data_q;
   assign bus.valid = valid_q;

`ifdef LOCK_BUFFER_STALL_CNT_EN
   logic stall_en_c;

   // Only a genuine stall counts; a flush cycle is not a lock cycle.
   assign stall_en_c = bus.dis & ~bus.flush;

   lock_buffer_sat_cnt u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (stall_en_c),
      .cnt   (bus.stall_cnt)
   );
`endif

endmodule

// File: tb/tb_lock_buffer.sv
// Directed table-driven bench for lock_buffer plus multi-cycle corner sequences.
module tb_lock_buffer;
   import lock_buffer_pkg::*;

   localparam int unsigned W = 16;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   lock_buffer_if #(.WIDTH(W)) bus ();

   lock_buffer #(.WIDTH(W), .FLUSH_VALUE(16'h0000)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic          rst_n;
      logic [W-1:0]  in;
      logic          dis;
      logic          flush;
      logic [W-1:0]  exp_out;
      logic          exp_valid;
      logic [15:0]   exp_cnt;
   } vec_t;

   vec_t vecs [15];

   int passed = 0;
   int total  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else passed++;
   endtask

   // Drive on the falling edge, sample 1 time unit after the next rising edge.
   task automatic step(input logic r, input logic [W-1:0] d, input logic s, input logic f);
      @(negedge clk);
      rst_n     = r;
      bus.in    = d;
      bus.dis   = s;
      bus.flush = f;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_cnt(input string name, input logic [15:0] exp);
`ifdef LOCK_BUFFER_STALL_CNT_EN
      chk(name, 32'(bus.stall_cnt), 32'(exp));
`else
      if (exp === 16'hxxxx) $display("unreachable %s", name);
`endif
   endtask

   initial begin
      logic [W-1:0] prev;
      logic [W-1:0] w;

      //           rst   in        dis   flush  out       valid cnt
      vecs[0]  = '{1'b0, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b0, 16'd0};
      vecs[1]  = '{1'b0, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b0, 16'd0};
      vecs[2]  = '{1'b1, 16'hAFAF, 1'b0, 1'b0, 16'hAFAF, 1'b1, 16'd0};
      vecs[3]  = '{1'b1, 16'hFAFA, 1'b0, 1'b0, 16'hFAFA, 1'b1, 16'd0};
      vecs[4]  = '{1'b1, 16'hFFFF, 1'b1, 1'b0, 16'hFAFA, 1'b1, 16'd1};
      vecs[5]  = '{1'b1, 16'h5555, 1'b1, 1'b0, 16'hFAFA, 1'b1, 16'd2};
      vecs[6]  = '{1'b1, 16'h1111, 1'b1, 1'b1, 16'h0000, 1'b0, 16'd2};
      vecs[7]  = '{1'b1, 16'h2222, 1'b0, 1'b1, 16'h0000, 1'b0, 16'd2};
      vecs[8]  = '{1'b1, 16'h5555, 1'b0, 1'b0, 16'h5555, 1'b1, 16'd2};
      vecs[9]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 16'h5555, 1'b1, 16'd3};
      vecs[10] = '{1'b1, 16'h7777, 1'b0, 1'b1, 16'h0000, 1'b0, 16'd3};
      vecs[11] = '{1'b1, 16'h8888, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd4};
      vecs[12] = '{1'b1, 16'h9999, 1'b0, 1'b0, 16'h9999, 1'b1, 16'd4};
      vecs[13] = '{1'b0, 16'hABCD, 1'b1, 1'b1, 16'h0000, 1'b0, 16'd0};
      vecs[14] = '{1'b1, 16'h0F0F, 1'b0, 1'b0, 16'h0F0F, 1'b1, 16'd0};

      rst_n = 1'b0; bus.in = '0; bus.dis = 1'b0; bus.flush = 1'b0;

      for (int i = 0; i < 15; i++) begin
         step(vecs[i].rst_n, vecs[i].in, vecs[i].dis, vecs[i].flush);
         chk($sformatf("vec%0d_out", i), 32'(bus.out), 32'(vecs[i].exp_out));
         chk($sformatf("vec%0d_valid", i), 32'(bus.valid), 32'(vecs[i].exp_valid));
         chk_cnt($sformatf("vec%0d_cnt", i), vecs[i].exp_cnt);
      end

      // Back-to-back loads: every word appears exactly one edge later.
      for (int i = 0; i < 8; i++) begin
         w = W'($urandom);
         step(1'b1, w, 1'b0, 1'b0);
         chk($sformatf("stream%0d_out", i), 32'(bus.out), 32'(w));
      end
      prev = w;

      // Held flush re-clears every cycle, even with changing data and lock.
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 16'hC0DE + W'(i), i[0], 1'b1);
         chk($sformatf("flush_hold%0d_out", i), 32'(bus.out), 32'h0000);
         chk($sformatf("flush_hold%0d_valid", i), 32'(bus.valid), 32'd0);
      end
      step(1'b1, 16'hBEEF, 1'b0, 1'b0);
      chk("flush_release_out", 32'(bus.out), 32'hBEEF);
      chk("flush_release_valid", 32'(bus.valid), 32'd1);
      if (prev === 16'hBEEF) $display("note: stream ended on release word");

      // Long lock: contents hold; counter saturates without wrapping.
`ifdef LOCK_BUFFER_STALL_CNT_EN
      step(1'b0, 16'h0000, 1'b0, 1'b0);
      step(1'b1, 16'h3C3C, 1'b0, 1'b0);
      for (int i = 0; i < 65540; i++) step(1'b1, W'(i), 1'b1, 1'b0);
      chk("sat_cnt", 32'(bus.stall_cnt), 32'h0000FFFF);
      chk("sat_hold_out", 32'(bus.out), 32'h3C3C);
      step(1'b1, 16'h0000, 1'b1, 1'b0);
      chk("sat_no_wrap", 32'(bus.stall_cnt), 32'h0000FFFF);
      step(1'b1, 16'h0000, 1'b1, 1'b1);
      chk("sat_flush_keeps_cnt", 32'(bus.stall_cnt), 32'h0000FFFF);
`else
      step(1'b1, 16'h3C3C, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b1, W'(i), 1'b1, 1'b0);
      chk("lock_hold_out", 32'(bus.out), 32'h3C3C);
      chk("lock_hold_valid", 32'(bus.valid), 32'd1);
`endif

      // Single-edge reset mid-operation restores all reset values.
      step(1'b0, 16'h7E7E, 1'b1, 1'b0);
      chk("midrst_out", 32'(bus.out), 32'h0000);
      chk("midrst_valid", 32'(bus.valid), 32'd0);
      chk_cnt("midrst_cnt", 16'd0);
      step(1'b1, 16'h6161, 1'b0, 1'b0);
      chk("post_rst_out", 32'(bus.out), 32'h6161);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
